// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared state encoding and width helpers for the bus arbiter
package arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_e;

    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_GAP      = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of a counter that must represent 0..max_count; never narrower than one bit.
    function automatic int counter_width(input int max_count);
        int w;
        w = clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/decoder.sv
// rtl/decoder.sv - binary index to one-hot decoder
module decoder #(
    parameter int P_width = 2
) (
    input  logic [P_width-1:0]      I_index,
    output logic [2**P_width-1:0]   O_onehot
);

    always_comb begin
        O_onehot          = '0;
        O_onehot[I_index] = 1'b1;
    end

endmodule

// File: rtl/rr_select.sv
// rtl/rr_select.sv - round-robin winner select: rotate, priority-encode, un-rotate
module rr_select #(
    parameter int P_width      = 2,
    parameter int P_requesters = 2**P_width
) (
    input  logic [P_requesters-1:0] I_candidates,
    input  logic [P_width-1:0]      I_last,
    output logic [P_width-1:0]      O_winner,
    output logic                    O_found
);

    logic [P_width-1:0]        start;
    logic [P_width-1:0]        offset;
    logic [2*P_requesters-1:0] doubled;
    logic [P_requesters-1:0]   rotated;

    always_comb begin
        start   = I_last + P_width'(1);
        doubled = {I_candidates, I_candidates} >> start;
        rotated = doubled[P_requesters-1:0];
        offset  = '0;
        O_found = 1'b0;
        // Downward scan so the lowest set bit (closest to start) wins.
        for (int i = P_requesters - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset  = P_width'(i);
                O_found = 1'b1;
            end
        end
        O_winner = start + offset;
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with urgency, max-hold rotation and turnaround gap
module bus_arbiter
    import arbiter_pkg::*;
#(
    parameter int P_width      = 2,
    parameter int P_requesters = 2**P_width,
    parameter int P_max_hold   = DEF_MAX_HOLD,
    parameter int P_gap        = DEF_GAP
) (
    input  logic                    I_clock,
    input  logic                    I_reset_n,
    input  logic [P_requesters-1:0] I_request,
    input  logic [P_requesters-1:0] I_urgent,
    input  logic                    I_done,
    output logic [P_requesters-1:0] O_grant,
    output logic [P_width-1:0]      O_grant_index,
    output logic                    O_grant_valid,
    output logic                    O_busy
);

    localparam int HOLD_W    = counter_width(P_max_hold);
    localparam int GAP_W     = counter_width(P_gap);
    localparam int HOLD_LAST = (P_max_hold > 0) ? P_max_hold - 1 : 0;
    localparam int GAP_LAST  = (P_gap > 0) ? P_gap - 1 : 0;

    arb_state_e              state_q, state_d;
    logic [P_width-1:0]      owner_q, owner_d;
    logic [P_width-1:0]      last_q, last_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [P_requesters-1:0] grant_q, grant_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;

    logic [P_requesters-1:0] urgent_req;
    logic [P_requesters-1:0] candidates;
    logic [P_width-1:0]      last_sel;
    logic [P_width-1:0]      win_idx;
    logic                    win_found;
    logic [P_requesters-1:0] next_onehot;
    logic                    release_grant;

    assign urgent_req = I_request & I_urgent;
    assign candidates = (|urgent_req) ? urgent_req : I_request;
    // When leaving GRANT the outgoing owner becomes the rotation origin in the same cycle.
    assign last_sel   = (state_q == ARB_GRANT) ? owner_q : last_q;

    rr_select #(
        .P_width      (P_width),
        .P_requesters (P_requesters)
    ) u_rr_select (
        .I_candidates (candidates),
        .I_last       (last_sel),
        .O_winner     (win_idx),
        .O_found      (win_found)
    );

    decoder #(
        .P_width (P_width)
    ) u_decoder (
        .I_index  (owner_d),
        .O_onehot (next_onehot)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        hold_d        = hold_q;
        gap_d         = gap_q;
        release_grant = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (win_found) begin
                    state_d = ARB_GRANT;
                    owner_d = win_idx;
                    hold_d  = '0;
                end
            end
            ARB_GRANT: begin
                if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                release_grant = I_done || !I_request[owner_q] ||
                                ((P_max_hold != 0) && (hold_q >= HOLD_W'(HOLD_LAST)) &&
                                 (|(I_request & ~grant_q)));
                if (release_grant) begin
                    last_d = owner_q;
                    hold_d = '0;
                    if (P_gap > 0) begin
                        state_d = ARB_GAP;
                        gap_d   = '0;
                    end else if (win_found) begin
                        owner_d = win_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    if (win_found) begin
                        state_d = ARB_GRANT;
                        owner_d = win_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        grant_d = (state_d == ARB_GRANT) ? next_onehot : '0;
        valid_d = (state_d == ARB_GRANT);
        busy_d  = (state_d != ARB_IDLE);
    end

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= '1;
            hold_q  <= '0;
            gap_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign O_grant       = grant_q;
    assign O_grant_index = owner_q;
    assign O_grant_valid = valid_q;
    assign O_busy        = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (gap=1 and gap=0 builds)
module tb_bus_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0;
    logic [3:0] urg = 4'b0;
    logic       done = 1'b0;

    logic [3:0] grant_a, grant_b;
    logic [1:0] index_a, index_b;
    logic       valid_a, valid_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, [0] = gap-1 build, [1] = gap-0 build; owner -1 means no grant.
    int m_owner[2];
    int m_last[2];
    int m_cnt[2];
    int m_gapl[2];
    int m_idx[2];

    always #5 clk = ~clk;

    bus_arbiter #(.P_width(2), .P_max_hold(MAXH), .P_gap(1)) dut_g1 (
        .I_clock(clk), .I_reset_n(rst_n), .I_request(req), .I_urgent(urg), .I_done(done),
        .O_grant(grant_a), .O_grant_index(index_a), .O_grant_valid(valid_a), .O_busy(busy_a)
    );

    bus_arbiter #(.P_width(2), .P_max_hold(MAXH), .P_gap(0)) dut_g0 (
        .I_clock(clk), .I_reset_n(rst_n), .I_request(req), .I_urgent(urg), .I_done(done),
        .O_grant(grant_b), .O_grant_index(index_b), .O_grant_valid(valid_b), .O_busy(busy_b)
    );

    function automatic int pick(logic [3:0] r, logic [3:0] ug, int last);
        logic [3:0] cand;
        cand = ((r & ug) != 4'd0) ? (r & ug) : r;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (cand[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1;
            m_last[u]  = N - 1;
            m_cnt[u]   = 0;
            m_gapl[u]  = 0;
            m_idx[u]   = 0;
        end
    endtask

    task automatic model_step(int u);
        int gap;
        bit rel;
        gap = (u == 0) ? 1 : 0;
        if (!rst_n) begin
            m_owner[u] = -1; m_last[u] = N - 1; m_cnt[u] = 0; m_gapl[u] = 0; m_idx[u] = 0;
            return;
        end
        if (m_owner[u] >= 0) begin
            m_cnt[u]++;
            rel = done || !req[m_owner[u]] ||
                  (m_cnt[u] >= MAXH && (req & ~(4'b1 << m_owner[u])) != 4'd0);
            if (rel) begin
                m_last[u] = m_owner[u];
                m_cnt[u]  = 0;
                if (gap > 0) begin
                    m_owner[u] = -1;
                    m_gapl[u]  = gap;
                end else begin
                    m_owner[u] = pick(req, urg, m_last[u]);
                end
            end
        end else if (m_gapl[u] > 0) begin
            if (m_gapl[u] == 1) begin
                m_gapl[u]  = 0;
                m_owner[u] = pick(req, urg, m_last[u]);
            end else begin
                m_gapl[u]--;
            end
        end else begin
            m_owner[u] = pick(req, urg, m_last[u]);
        end
        if (m_owner[u] >= 0) m_idx[u] = m_owner[u];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req = 4'b0; urg = 4'b0; done = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (grant_a !== 4'b0) $display("FAIL reset_grant got %b expected 0000", grant_a); else n_pass++;
        n_checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid got %b expected 0", valid_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy_a); else n_pass++;
        n_checks++; if (index_a !== 2'd0) $display("FAIL reset_index got %0d expected 0", index_a); else n_pass++;
        n_checks++; if (grant_b !== 4'b0) $display("FAIL reset_grant_g0 got %b expected 0000", grant_b); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (busy_a !== 1'b0) $display("FAIL idle_busy got %b expected 0", busy_a); else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0001;
        tick();
        n_checks++; if (grant_a !== 4'b0001) $display("FAIL single_grant got %b expected 0001", grant_a); else n_pass++;
        n_checks++; if (index_a !== 2'd0) $display("FAIL single_index got %0d expected 0", index_a); else n_pass++;
        n_checks++; if (valid_a !== 1'b1) $display("FAIL single_valid got %b expected 1", valid_a); else n_pass++;
        tick();
        tick();
        done = 1'b1; req = 4'b0000;
        tick();
        done = 1'b0;
        n_checks++; if (grant_a !== 4'b0) $display("FAIL single_gap_grant got %b expected 0000", grant_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL single_gap_busy got %b expected 1", busy_a); else n_pass++;
        tick();
        n_checks++; if (busy_a !== 1'b0) $display("FAIL single_idle_busy got %b expected 0", busy_a); else n_pass++;
        n_checks++; if (index_a !== 2'd0) $display("FAIL single_index_hold got %0d expected 0", index_a); else n_pass++;
    endtask

    task automatic test_rotation();
        logic [3:0] seq [9];
        seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        apply_reset();
        req = 4'b1111; done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if (grant_a !== seq[i]) $display("FAIL rotation[%0d] got %b expected %b", i, grant_a, seq[i]);
            else n_pass++;
        end
        req = 4'b0; done = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_urgency();
        apply_reset();
        req = 4'b0001;
        tick();
        req = 4'b0111; urg = 4'b0100; done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_checks++; if (grant_a !== 4'b0100) $display("FAIL urgent_win got %b expected 0100", grant_a); else n_pass++;
        apply_reset();
        req = 4'b0001;
        tick();
        req = 4'b0011; urg = 4'b1000; done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_checks++; if (grant_a !== 4'b0010) $display("FAIL urgent_ignored got %b expected 0010", grant_a); else n_pass++;
        req = 4'b0; urg = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_max_hold();
        logic [3:0] seq [6];
        int bad;
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
        apply_reset();
        req = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (grant_a !== seq[i]) $display("FAIL max_hold[%0d] got %b expected %b", i, grant_a, seq[i]);
            else n_pass++;
        end
        apply_reset();
        req = 4'b0001;
        bad = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (grant_a !== 4'b0001 || valid_a !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL lone_hold got %0d bad cycles expected 0", bad); else n_pass++;
        req = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0100;
        tick();
        n_checks++; if (grant_a !== 4'b0100) $display("FAIL pre_reset_grant got %b expected 0100", grant_a); else n_pass++;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (grant_a !== 4'b0) $display("FAIL async_grant got %b expected 0000", grant_a); else n_pass++;
        n_checks++; if (valid_a !== 1'b0) $display("FAIL async_valid got %b expected 0", valid_a); else n_pass++;
        #1 rst_n = 1'b1;
        req = 4'b1111;
        tick();
        n_checks++; if (grant_a !== 4'b0001) $display("FAIL post_reset_grant got %b expected 0001", grant_a); else n_pass++;
        req = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req = 4'b0011;
        tick();
        n_checks++; if (grant_b !== 4'b0001) $display("FAIL b2b_first got %b expected 0001", grant_b); else n_pass++;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++; if (grant_b !== 4'b0010) $display("FAIL b2b_second got %b expected 0010", grant_b); else n_pass++;
        n_checks++; if (valid_b !== 1'b1) $display("FAIL b2b_valid got %b expected 1", valid_b); else n_pass++;
        n_checks++; if (index_b !== 2'd1) $display("FAIL b2b_index got %0d expected 1", index_b); else n_pass++;
        req = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [3:0] eg, ag;
        logic [1:0] ai;
        logic       av, ab;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            end
            urg  = 4'($urandom) & 4'($urandom);
            done = ($urandom_range(0, 5) == 0);
            tick();
            for (int u = 0; u < 2; u++) begin
                ag = (u == 0) ? grant_a : grant_b;
                ai = (u == 0) ? index_a : index_b;
                av = (u == 0) ? valid_a : valid_b;
                ab = (u == 0) ? busy_a  : busy_b;
                eg = (m_owner[u] >= 0) ? 4'(1 << m_owner[u]) : 4'b0;
                n_checks++;
                if (ag !== eg) $display("FAIL random_grant dut%0d cycle %0d got %b expected %b", u, cyc, ag, eg);
                else n_pass++;
                n_checks++;
                if (ai !== 2'(m_idx[u])) $display("FAIL random_index dut%0d cycle %0d got %0d expected %0d", u, cyc, ai, m_idx[u]);
                else n_pass++;
                n_checks++;
                if (av !== (m_owner[u] >= 0)) $display("FAIL random_valid dut%0d cycle %0d got %b expected %b", u, cyc, av, m_owner[u] >= 0);
                else n_pass++;
                n_checks++;
                if (ab !== (m_owner[u] >= 0 || m_gapl[u] > 0))
                    $display("FAIL random_busy dut%0d cycle %0d got %b expected %b", u, cyc, ab, m_owner[u] >= 0 || m_gapl[u] > 0);
                else n_pass++;
            end
        end
        req = 4'b0; urg = 4'b0; done = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_urgency();
        test_max_hold();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
